// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/cla_nibble.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3.
module cla_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c3, c2, c1, ci};
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Valid/ready adder that sums WIDTH-bit operands one nibble per cycle through
// a single shared lookahead slice.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned NumNib = WIDTH / NIBBLE_W;
  localparam int unsigned IdxW   = (NumNib > 1) ? $clog2(NumNib) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumNib - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [IdxW-1:0]  idx_q;
  logic             carry_q, cout_q, ovf_q;
  logic             load, step, last;
  logic [3:0]       nib_s;
  logic             nib_co, nib_c3;

  assign last = (idx_q == LastIdx);

  cla_nibble u_cla (
    .a  (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b  (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co),
    .c3 (nib_c3)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          // Output handshake and new input handshake share this cycle.
          if (in_valid) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q     <= A;
        b_q     <= B;
        carry_q <= Cin;
        idx_q   <= '0;
      end else if (step) begin
        s_q[idx_q*NIBBLE_W +: NIBBLE_W] <= nib_s;
        carry_q <= nib_co;
        if (last) begin
          cout_q <= nib_co;
          ovf_q  <= nib_c3 ^ nib_co;
        end else begin
          idx_q <= idx_q + IdxW'(1);
        end
      end
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomised checks of nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  // Offer operands while the DUT is ready; returns one cycle after the handshake edge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    in_valid = 1'b1;
    A = a;
    B = b;
    Cin = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycle index (handshake cycle = 0) at which out_valid is first seen; 0 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        cyc = n;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, input logic [W-1:0] es, input logic ec,
                              input logic eo);
    int cyc;
    out_ready = 1'b1;
    start(a, b, c);
    wait_done(cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 5", name, cyc);
    end
    checks++;
    if ({S, Cout, Ovf} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL %s result: got S=%h Cout=%b Ovf=%b, expected S=%h Cout=%b Ovf=%b",
               name, S, Cout, Ovf, es, ec, eo);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, S, Cout, Ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b S=%h Cout=%b Ovf=%b, expected 1 0 0000 0 0",
               in_ready, out_valid, S, Cout, Ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run_directed("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
  endtask

  task automatic test_carry_ripple();
    run_directed("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    run_directed("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_directed("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b0;
    start(16'h00FF, 16'h0F01, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles, expected 5", cyc);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready, S, Cout, Ovf} !== {1'b1, 1'b0, 16'h1001, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: got out_valid=%b in_ready=%b S=%h Cout=%b Ovf=%b, expected 1 0 1001 0 0",
                 i, out_valid, in_ready, S, Cout, Ovf);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    A = 16'h0001;
    B = 16'h0002;
    Cin = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, S} !== {1'b1, 16'h1001}) begin
      errors++;
      $display("FAIL b2b_accept: got in_ready=%b S=%h, expected 1 1001", in_ready, S);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_run: got out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    wait_done(cyc);
    checks++;
    if (cyc !== 4 || {S, Cout, Ovf} !== {16'h0003, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: got cyc=%0d S=%h Cout=%b Ovf=%b, expected cyc=4 S=0003 0 0",
               cyc, S, Cout, Ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    start(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, S} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL midrun_reset: got in_ready=%b out_valid=%b S=%h, expected 1 0 0000",
               in_ready, out_valid, S);
    end
    @(posedge clk);
    #1;
    run_directed("after_reset", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, es, held;
    logic         c, eo, seen;
    logic [W:0]   full;
    bit           done;
    for (int t = 0; t < 1000; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      es = full[W-1:0];
      eo = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);
      out_ready = 1'($urandom);
      start(a, b, c);
      done = 1'b0;
      seen = 1'b0;
      held = '0;
      for (int n = 0; n < 40 && !done; n++) begin
        @(negedge clk);
        if (out_valid) begin
          if (seen && S !== held) begin
            checks++;
            errors++;
            $display("FAIL rand_hold[%0d]: got S=%h, expected %h", t, S, held);
          end
          seen = 1'b1;
          held = S;
          if (out_ready) begin
            done = 1'b1;
            checks++;
            if ({S, Cout, Ovf} !== {es, full[W], eo}) begin
              errors++;
              $display("FAIL rand[%0d] %h+%h+%b: got S=%h Cout=%b Ovf=%b, expected S=%h Cout=%b Ovf=%b",
                       t, a, b, c, S, Cout, Ovf, es, full[W], eo);
            end
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'($urandom);
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout[%0d]: got no result within 40 cycles, expected one", t);
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operand set offered.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operand set this cycle.
REQ-006 SHALL have port A, input, WIDTH bits: operand A.
REQ-007 SHALL have port B, input, WIDTH bits: operand B.
REQ-008 SHALL have port Cin, input, 1 bit: carry-in.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port S, output, WIDTH bits: sum.
REQ-012 SHALL have port Cout, output, 1 bit: carry-out of the MSB.
REQ-013 SHALL have port Ovf, output, 1 bit: signed overflow (carry into MSB XOR Cout).

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 in IDLE, and in DONE only when out_ready=1; it SHALL be 0 otherwise.
REQ-016 On an input handshake (in_valid & in_ready), the block SHALL register A, B and Cin, clear the nibble index to 0, load the carry register with Cin, and enter RUN.
REQ-017 In RUN, each cycle SHALL add nibble k of A and B plus the carry register through a 4-bit carry-lookahead slice (g=a&b, p=a^b, lookahead carries), write the slice sum into S[4k+3:4k], update the carry register with the slice carry-out, and increment k.
REQ-018 When the processed nibble is k=WIDTH/4-1, the block SHALL enter DONE; Cout SHALL take the slice carry-out and Ovf SHALL take the slice's internal carry into bit 3 XOR its carry-out.
REQ-019 Latency SHALL be WIDTH/4+1 cycles from the handshake edge to out_valid=1 (5 cycles for WIDTH=16).
REQ-020 out_valid SHALL be 1 exactly in DONE; S, Cout and Ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 In DONE with out_ready=1 and in_valid=0, the block SHALL go to IDLE.
REQ-022 In DONE with out_ready=1 and in_valid=1, the block SHALL complete the output handshake and accept the new operands in the same cycle, going directly to RUN with no idle bubble.
REQ-023 in_valid asserted during RUN SHALL be ignored; the registered operands SHALL NOT change.
REQ-024 The nibble index SHALL be ceil(log2(WIDTH/4)) bits wide and SHALL NOT wrap within a transaction.
REQ-025 Sum arithmetic SHALL be modulo 2^WIDTH, with the carry reported only on Cout.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL enter IDLE and clear S, Cout, Ovf, the carry register, the nibble index and the operand registers to 0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the transaction and discard the partial result.
REQ-028 The first handshake after reset SHALL be possible in the cycle after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE) and the constant NIBBLE_W=4.
REQ-030 The combinational 4-bit lookahead slice SHALL be a sub-module named cla_nibble, with ports a[3:0], b[3:0], ci, s[3:0], co and c3; c3 is the carry into bit 3.
REQ-031 The design SHALL contain exactly one cla_nibble instance; no WIDTH-wide adder SHALL be inferred.

Verification
REQ-032 With A=0x1234, B=0x1111, Cin=0: S=0x2345, Cout=0, Ovf=0, and out_valid SHALL rise 5 cycles after the handshake.
REQ-033 With A=0xFFFF, B=0x0000, Cin=1: S=0x0000, Cout=1, Ovf=0, verifying carry ripple across all 4 nibbles.
REQ-034 With A=0x7FFF, B=0x0001, Cin=0: S=0x8000, Cout=0, Ovf=1; with A=0x8000, B=0x8000: S=0x0000, Cout=1, Ovf=1.
REQ-035 Hold out_ready=0 for 3 cycles in DONE, then pulse it together with in_valid: S SHALL stay stable throughout, and the next transaction SHALL enter RUN in the same cycle.
REQ-036 Assert rst at the 2nd RUN cycle: the following cycle SHALL show IDLE, in_ready=1, out_valid=0 and S=0, and a subsequent transaction SHALL complete correctly.
REQ-037 Apply 1000 random operand sets with random out_ready back-pressure and compare each result against a WIDTH-bit reference model, including WIDTH=8 and WIDTH=32 builds.
